imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage of the pipelined RV core. It covers every base-ISA immediate format (I, S, B, U, J), plus CSR zimm and shift-amount. It produces a full-width, correctly shifted immediate; B and J include the implicit zero LSB. The block registers its result through PIPE_STAGES stages and obeys the core's stall/flush controls, so it drops into the ID/EX boundary without extra glue.

Parameters:
XLEN, 32, datapath width of imm_out; legal values 32 or 64.
PIPE_STAGES, 1, register stages between input and output; legal values 1 or 2.
SEL_W, 3, width of the format selector.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  instr/imm_sel are valid this cycle.
instr  input  32  raw instruction word.
imm_sel  input  SEL_W  format selector (encodings in Behaviour).
stall  input  1  hold every stage; in_valid ignored.
flush  input  1  kill every in-flight entry.
out_valid  output  1  imm_out/imm_sel_out/illegal_sel valid.
imm_out  output  XLEN  extended immediate.
imm_sel_out  output  SEL_W  selector travelling with imm_out.
illegal_sel  output  1  selector was the reserved code.

Behaviour:
- Selector encodings:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25],instr[11:7]}).
  - 010 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 011 U: sext({instr[31:12],12'b0}).
  - 100 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 101 Z: zext(instr[19:15]).
  - 110 SH: zext(instr[25:20]) when XLEN=64, zext(instr[24:20]) when XLEN=32.
  - 111: imm_out=0, illegal_sel=1.
- Sign extension always replicates instr[31] up to bit XLEN-1.
- Extraction is purely combinational and precedes stage 1. All outputs are registered.
- Latency: an entry accepted at edge N (in_valid=1, stall=0, flush=0) appears with out_valid=1 after edge N+PIPE_STAGES-1, i.e. at the PIPE_STAGES-th edge counting N. Throughput is one entry per cycle.
- Stage update, evaluated per edge:
  - rst=1: all valid bits 0, all data registers 0.
  - else flush=1: all valid bits 0; data registers may keep their values.
  - else stall=1: all stage registers hold their values.
  - else: each stage loads the previous stage; stage 1 loads the extracted values and valid=in_valid.
- Priority is rst > flush > stall > advance. Flush and stall together resolve as a flush.
- in_valid=0 with no stall inserts a bubble. Bubble data is don't-care, but out_valid must be 0 for it.
- Reset values: out_valid=0, imm_out=0, imm_sel_out=0, illegal_sel=0.
- Reset asserted mid-stream discards every in-flight entry. The first valid output after reset requires a fresh acceptance.
- Any PIPE_STAGES value other than 1 or 2, or any XLEN other than 32 or 64, is a configuration error. The design flags it with an elaboration-time $error.

Decomposition:
- Package imm_pkg:
  - selector localparams IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH, IMM_RSVD;
  - SEL_W default;
  - XLEN legality constants.
- Sub-module imm_extract: combinational, parametrised on XLEN. Takes instr and imm_sel, returns imm and illegal.
- imm_gen_pipe instantiates imm_extract and a generate loop of PIPE_STAGES stage registers.

Test Plan:
- XLEN=32, PIPE_STAGES=1:
  - I instr=0xFFF00093 -> imm_out=0xFFFFFFFF, out_valid=1 after one edge.
  - S 0xFE112E23 -> 0xFFFFFFFC.
- B 0xFE000CE3 -> 0xFFFFFFF8. U 0x123450B7 -> 0x12345000. J 0x001000EF -> 0x00000800.
- XLEN=64, PIPE_STAGES=2:
  - I 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF, out_valid two edges after acceptance.
  - SH instr=0x03F09093 -> 0x3F.
- PIPE_STAGES=2, stream of three entries:
  - stall held 3 cycles mid-stream -> outputs frozen, no entry lost or duplicated;
  - after release, order is preserved.
- Flush asserted together with stall while 2 entries are in flight -> out_valid=0 on the next cycle. The next accepted entry emerges normally.
- Selector 111 -> imm_out=0, illegal_sel=1.
- rst asserted with valid entries in flight -> all outputs 0 on the next edge, and out_valid stays 0 until a new acceptance.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared selector encodings and configuration constants for the immediate generator.
package imm_pkg;

  localparam int IMM_SEL_W = 3;

  localparam logic [IMM_SEL_W-1:0] IMM_I    = 3'b000;
  localparam logic [IMM_SEL_W-1:0] IMM_S    = 3'b001;
  localparam logic [IMM_SEL_W-1:0] IMM_B    = 3'b010;
  localparam logic [IMM_SEL_W-1:0] IMM_U    = 3'b011;
  localparam logic [IMM_SEL_W-1:0] IMM_J    = 3'b100;
  localparam logic [IMM_SEL_W-1:0] IMM_Z    = 3'b101;
  localparam logic [IMM_SEL_W-1:0] IMM_SH   = 3'b110;
  localparam logic [IMM_SEL_W-1:0] IMM_RSVD = 3'b111;

  localparam int XLEN_RV32 = 32;
  localparam int XLEN_RV64 = 64;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for every base-ISA format plus zimm/shamt.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SEL_W = IMM_SEL_W
) (
  input  logic [31:0]      instr,
  input  logic [SEL_W-1:0] imm_sel,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);

  // Every format is first assembled as a 32-bit value; the zero-extended
  // ones have a clear top bit, so one sign-extending cast widens them all.
  logic [31:0] raw;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    case (imm_sel)
      SEL_W'(IMM_I):  raw = {{20{instr[31]}}, instr[31:20]};
      SEL_W'(IMM_S):  raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SEL_W'(IMM_B):  raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
      SEL_W'(IMM_U):  raw = {instr[31:12], 12'b0};
      SEL_W'(IMM_J):  raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
      SEL_W'(IMM_Z):  raw = {27'b0, instr[19:15]};
      SEL_W'(IMM_SH): raw = (XLEN == XLEN_RV64) ? {26'b0, instr[25:20]}
                                                : {27'b0, instr[24:20]};
      default:        illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator registered through PIPE_STAGES stall/flush-aware stages.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int SEL_W       = IMM_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  input  logic [SEL_W-1:0] imm_sel,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [XLEN-1:0]  imm_out,
  output logic [SEL_W-1:0] imm_sel_out,
  output logic             illegal_sel
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
    $error("imm_gen_pipe: PIPE_STAGES must be 1 or 2");
  end

  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;

  imm_extract #(
    .XLEN  (XLEN),
    .SEL_W (SEL_W)
  ) u_extract (
    .instr   (instr),
    .imm_sel (imm_sel),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  // Valid semantics: in_valid qualifies instr/imm_sel for one cycle and is
  // accepted on any edge without rst/flush/stall; there is no ready, stall is
  // the only backpressure and holds every stage, flush clears every valid bit.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    logic             vld_d, vld_q;
    logic [XLEN-1:0]  imm_d, imm_q;
    logic [SEL_W-1:0] sel_d, sel_q;
    logic             ill_d, ill_q;

    if (s == 0) begin : g_head
      assign vld_d = in_valid;
      assign imm_d = ext_imm;
      assign sel_d = imm_sel;
      assign ill_d = ext_illegal;
    end else begin : g_tail
      assign vld_d = g_stage[s-1].vld_q;
      assign imm_d = g_stage[s-1].imm_q;
      assign sel_d = g_stage[s-1].sel_q;
      assign ill_d = g_stage[s-1].ill_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        imm_q <= '0;
        sel_q <= '0;
        ill_q <= 1'b0;
      end else if (flush) begin
        vld_q <= 1'b0;
      end else if (!stall) begin
        vld_q <= vld_d;
        imm_q <= imm_d;
        sel_q <= sel_d;
        ill_q <= ill_d;
      end
    end
  end

  assign out_valid   = g_stage[PIPE_STAGES-1].vld_q;
  assign imm_out     = g_stage[PIPE_STAGES-1].imm_q;
  assign imm_sel_out = g_stage[PIPE_STAGES-1].sel_q;
  assign illegal_sel = g_stage[PIPE_STAGES-1].ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: RV32 single-stage and RV64 two-stage instances with hand-computed immediates.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // instance a: XLEN=32, PIPE_STAGES=1
  logic        a_valid, a_stall, a_flush;
  logic [31:0] a_instr;
  logic [2:0]  a_sel;
  logic        a_out_valid, a_illegal;
  logic [31:0] a_imm;
  logic [2:0]  a_sel_out;

  // instance b: XLEN=64, PIPE_STAGES=2
  logic        b_valid, b_stall, b_flush;
  logic [31:0] b_instr;
  logic [2:0]  b_sel;
  logic        b_out_valid, b_illegal;
  logic [63:0] b_imm;
  logic [2:0]  b_sel_out;

  imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(1), .SEL_W(3)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .instr(a_instr), .imm_sel(a_sel),
    .stall(a_stall), .flush(a_flush), .out_valid(a_out_valid), .imm_out(a_imm),
    .imm_sel_out(a_sel_out), .illegal_sel(a_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(2), .SEL_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .instr(b_instr), .imm_sel(b_sel),
    .stall(b_stall), .flush(b_flush), .out_valid(b_out_valid), .imm_out(b_imm),
    .imm_sel_out(b_sel_out), .illegal_sel(b_illegal)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] ins, input logic [2:0] sel);
    a_valid = v; a_instr = ins; a_sel = sel;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                         input logic st, input logic fl);
    b_valid = v; b_instr = ins; b_sel = sel; b_stall = st; b_flush = fl;
  endtask

  task automatic scoreboard_pop(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 64'd1, 64'd0);
    end else begin
      held = exp_q.pop_front();
      check({tag, "_valid"}, 64'(b_out_valid), 64'd1);
      check({tag, "_imm"}, b_imm, held);
    end
  endtask

  logic [31:0] va_instr [9];
  logic [2:0]  va_sel   [9];
  logic [31:0] va_exp   [9];

  initial begin
    va_instr[0] = 32'hFFF00093; va_sel[0] = 3'b000; va_exp[0] = 32'hFFFFFFFF;
    va_instr[1] = 32'h7FF00093; va_sel[1] = 3'b000; va_exp[1] = 32'h000007FF;
    va_instr[2] = 32'hFE112E23; va_sel[2] = 3'b001; va_exp[2] = 32'hFFFFFFFC;
    va_instr[3] = 32'hFE000CE3; va_sel[3] = 3'b010; va_exp[3] = 32'hFFFFFFF8;
    va_instr[4] = 32'h123450B7; va_sel[4] = 3'b011; va_exp[4] = 32'h12345000;
    va_instr[5] = 32'h001000EF; va_sel[5] = 3'b100; va_exp[5] = 32'h00000800;
    va_instr[6] = 32'hFFFF8FFF; va_sel[6] = 3'b101; va_exp[6] = 32'h0000001F;
    va_instr[7] = 32'h03F09093; va_sel[7] = 3'b110; va_exp[7] = 32'h0000001F;
    va_instr[8] = 32'hFFFFFFFF; va_sel[8] = 3'b111; va_exp[8] = 32'h00000000;

    a_stall = 1'b0; a_flush = 1'b0;
    drive_a(1'b0, 32'h0, 3'b000);
    drive_b(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) step();
    check("rst_a_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_imm", 64'(a_imm), 64'd0);
    check("rst_b_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_imm", b_imm, 64'd0);
    check("rst_b_sel", 64'(b_sel_out), 64'd0);
    check("rst_b_illegal", 64'(b_illegal), 64'd0);
    rst = 1'b0;

    // RV32, one stage: result is visible right after the accepting edge
    for (int i = 0; i < 9; i++) begin
      drive_a(1'b1, va_instr[i], va_sel[i]);
      step();
      check($sformatf("a%0d_valid", i), 64'(a_out_valid), 64'd1);
      check($sformatf("a%0d_imm", i), 64'(a_imm), 64'(va_exp[i]));
      check($sformatf("a%0d_sel", i), 64'(a_sel_out), 64'(va_sel[i]));
      check($sformatf("a%0d_illegal", i), 64'(a_illegal), (i == 8) ? 64'd1 : 64'd0);
    end
    drive_a(1'b0, 32'h0, 3'b000);
    step();
    check("a_bubble", 64'(a_out_valid), 64'd0);

    // RV64, two stages: I-type
    drive_b(1'b1, 32'hFFF00093, 3'b000, 1'b0, 1'b0);
    step();
    check("b_i_lat1", 64'(b_out_valid), 64'd0);
    drive_b(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    step();
    check("b_i_valid", 64'(b_out_valid), 64'd1);
    check("b_i_imm", b_imm, 64'hFFFFFFFFFFFFFFFF);

    // RV64 shamt uses six bits
    drive_b(1'b1, 32'h03F09093, 3'b110, 1'b0, 1'b0);
    step();
    drive_b(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    step();
    check("b_sh_valid", 64'(b_out_valid), 64'd1);
    check("b_sh_imm", b_imm, 64'h3F);

    // reserved selector
    drive_b(1'b1, 32'hFFFFFFFF, 3'b111, 1'b0, 1'b0);
    step();
    drive_b(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    step();
    check("b_rsvd_imm", b_imm, 64'h0);
    check("b_rsvd_illegal", 64'(b_illegal), 64'd1);
    check("b_rsvd_sel", 64'(b_sel_out), 64'd7);
    step();
    check("b_rsvd_drain", 64'(b_out_valid), 64'd0);

    // three-entry stream with a 3-cycle stall after the first emerges
    exp_q.push_back(64'h0000000011111000);
    exp_q.push_back(64'h0000000022222000);
    exp_q.push_back(64'hFFFFFFFF83333000);
    drive_b(1'b1, 32'h11111037, 3'b011, 1'b0, 1'b0);
    step();
    check("st_lat1", 64'(b_out_valid), 64'd0);
    drive_b(1'b1, 32'h22222037, 3'b011, 1'b0, 1'b0);
    step();
    scoreboard_pop("st_e1");
    drive_b(1'b1, 32'h83333037, 3'b011, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("st_hold%0d_valid", i), 64'(b_out_valid), 64'd1);
      check($sformatf("st_hold%0d_imm", i), b_imm, held);
    end
    drive_b(1'b1, 32'h83333037, 3'b011, 1'b0, 1'b0);
    step();
    scoreboard_pop("st_e2");
    drive_b(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    step();
    scoreboard_pop("st_e3");
    step();
    check("st_drain", 64'(b_out_valid), 64'd0);
    check("st_q_empty", 64'(exp_q.size()), 64'd0);

    // flush together with stall while two entries are in flight
    drive_b(1'b1, 32'h7FF00093, 3'b000, 1'b0, 1'b0);
    step();
    drive_b(1'b1, 32'h80000093, 3'b000, 1'b0, 1'b0);
    step();
    check("fl_pre_valid", 64'(b_out_valid), 64'd1);
    check("fl_pre_imm", b_imm, 64'h7FF);
    drive_b(1'b1, 32'h12300093, 3'b000, 1'b1, 1'b1);
    step();
    check("fl_valid", 64'(b_out_valid), 64'd0);
    drive_b(1'b1, 32'h12300093, 3'b000, 1'b0, 1'b0);
    step();
    check("fl_no_ghost", 64'(b_out_valid), 64'd0);
    drive_b(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    step();
    check("fl_next_valid", 64'(b_out_valid), 64'd1);
    check("fl_next_imm", b_imm, 64'h123);
    step();

    // reset with entries in flight
    drive_b(1'b1, 32'hFE000CE3, 3'b010, 1'b0, 1'b0);
    step();
    drive_b(1'b1, 32'h001000EF, 3'b100, 1'b0, 1'b0);
    step();
    check("mr_pre_valid", 64'(b_out_valid), 64'd1);
    rst = 1'b1;
    step();
    check("mr_valid", 64'(b_out_valid), 64'd0);
    check("mr_imm", b_imm, 64'h0);
    check("mr_sel", 64'(b_sel_out), 64'd0);
    check("mr_illegal", 64'(b_illegal), 64'd0);
    rst = 1'b0;
    drive_b(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    step();
    check("mr_after1", 64'(b_out_valid), 64'd0);
    step();
    check("mr_after2", 64'(b_out_valid), 64'd0);
    drive_b(1'b1, 32'hFE112E23, 3'b001, 1'b0, 1'b0);
    step();
    drive_b(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    step();
    check("mr_fresh_valid", 64'(b_out_valid), 64'd1);
    check("mr_fresh_imm", b_imm, 64'hFFFFFFFFFFFFFFFC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
